spm_mac: RTL and testbench
==========================

# spm_mac

Parametrised serial-parallel multiply-accumulate unit, the next generation of the `spm` multiplier. It accepts a WIDTH-bit parallel operand `a` and a WIDTH-bit operand `x` through a valid/ready handshake. It serialises `x` internally and produces the exact 2·WIDTH-bit product, both as an LSB-first serial bit stream and as a parallel result with an optional running accumulate. It supports unsigned and two's-complement signed modes, so the external shift registers `spm` needed for sequencing and collection are no longer required.

## Interface
- `WIDTH`, default 32: operand width in bits; legal range WIDTH ≥ 2. The product and accumulator are 2·WIDTH bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  high only in IDLE.
- `x`  in  WIDTH  multiplier operand, serialised LSB-first internally.
- `a`  in  WIDTH  parallel multiplicand.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned.
- `accumulate`  in  1  1 = add the new product to the current `p`; 0 = overwrite `p`.
- `serial_y`  out  1  product bit stream, LSB first.
- `serial_valid`  out  1  qualifies `serial_y`.
- `busy`  out  1  high from operand accept until result accept.
- `out_valid`  out  1  `p` holds a completed result.
- `out_ready`  in  1  result consumer ready.
- `p`  out  2·WIDTH  result / accumulator register.

## Operation
- FSM has three states:
  - IDLE: `in_ready`=1.
  - RUN: 2·WIDTH cycles; one `x` bit is consumed and one product bit is emitted per cycle.
  - DONE: `out_valid`=1.
- Operand accept: on an edge where IDLE, `in_valid` and `in_ready` are all high, the block latches `x`, `a`, `signed_mode` and `accumulate`, then moves IDLE→RUN. Inputs are don't-care after the accept edge.
- Arithmetic:
  - Unsigned mode: product = x·a, zero-extended to 2·WIDTH bits.
  - Signed mode: product = x·a computed as two's complement. `x` is sign-extended for cycles WIDTH..2·WIDTH-1, and `a` is sign-extended in the partial products. The result is exact in 2·WIDTH bits.
- RUN→DONE on the edge ending the 2·WIDTH-th RUN cycle. On that same edge, `p` ← product, or `p` ← (`p` + product) mod 2^(2·WIDTH) if the latched `accumulate`=1. Wrap is silent, with no overflow flag.
- DONE→IDLE on an edge with `out_valid` and `out_ready` both high. `p` keeps its value after this handshake until the next completion.
- `serial_y` carries the product bits only, without the accumulate contribution.
- No overlap between operations: `in_ready`=0 in RUN and DONE, and a new operand is never accepted on the same edge as a result handshake.
- `out_ready` high before DONE has no effect.
- `in_valid` held high while busy is ignored until IDLE.

## Timing
- Reset values while `rst`=0: state=IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, `serial_valid`=0, `serial_y`=0, `p`=0. The internal counter and shift registers are cleared.
- Reset mid-RUN or mid-DONE: the operation is abandoned immediately, asynchronously. The accumulator is lost (`p`=0), and no `out_valid` pulse is produced.
- Let E0 be the accept edge.
  - `busy` and `serial_valid` rise immediately after E0.
  - Product bit k (k = 0..2·WIDTH-1) appears on `serial_y` in the k-th cycle after E0, i.e. it is stable between edges E0+k and E0+k+1.
- At edge E0+2·WIDTH:
  - `serial_valid` falls.
  - `out_valid` rises.
  - `p` updates.
- Latency from accept to result: 2·WIDTH cycles.
- If `out_ready` is held high, a result handshake occurs at edge E0+2·WIDTH+1. `in_ready` is high after that edge, so the maximum throughput is one operation per 2·WIDTH+2 cycles.
- While `out_valid`=1 with `out_ready`=0, `p` and `out_valid` hold stable indefinitely.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan
Benches run at WIDTH=8 unless stated otherwise.
- Unsigned extremes: x=0xFF, a=0xFF, accumulate=0 → `p`=0xFE01 at E0+16. The serial stream LSB-first reassembles to 0xFE01. x=0, a=0xA5 → `p`=0x0000.
- Signed corners:
  - −1·−1 (0xFF, 0xFF) → 0x0001.
  - −128·−128 (0x80, 0x80) → 0x4000.
  - −128·127 (0x80, 0x7F) → 0xC080.
  - 0x7F·0x7F → 0x3F01.
- Accumulate and wrap:
  - 3·5 with accumulate=0 → 0x000F; then 2·7 with accumulate=1 → 0x001D.
  - Unsigned 0xFF·0xFF with accumulate=0, then the same operands with accumulate=1 → 0xFC02 (wrapped mod 2^16).
- Backpressure: hold `out_ready`=0 for 10 cycles after DONE → `p` and `out_valid` stay stable and `in_ready`=0 despite `in_valid`=1. Raise `out_ready` → IDLE next edge; the next operand is accepted no earlier than the edge after that.
- Reset mid-run: assert `rst`=0 at cycle 5 of RUN → all outputs drop to reset values at once, with no `out_valid`. After release, 6·9 unsigned → `p`=0x0036.
- Randomised: WIDTH=32 and WIDTH=5, 200 random operand/mode/accumulate sets each with random `out_ready` stalls. Each result must match the reference model (mod 2^(2·WIDTH)), and each latency must equal exactly 2·WIDTH cycles.

Source files
------------

// File: rtl/spm_mac.sv
// -----------------------------------------------------------------------------
// spm_mac -- serial-parallel multiply-accumulate unit.
//
// Takes a WIDTH-bit multiplicand `a` and multiplier `x` through a valid/ready
// handshake. It walks `x` LSB-first, one bit per cycle, for 2*WIDTH cycles.
// Each cycle it emits one exact product bit on `serial_y`. On completion it
// loads the full 2*WIDTH-bit product into `p`, or adds it to `p`.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   in_valid      operand request; accepted only while IDLE
//   in_ready      high only in IDLE
//   x, a          multiplier / multiplicand (WIDTH bits)
//   signed_mode   1 = two's-complement operands, 0 = unsigned
//   accumulate    1 = p <= p + product, 0 = p <= product
//   serial_y      product bit stream, LSB first
//   serial_valid  qualifies serial_y (high for the 2*WIDTH RUN cycles)
//   busy          high from operand accept until result accept
//   out_valid     p holds a completed result
//   out_ready     result consumer ready
//   p             2*WIDTH-bit result / accumulator register
// -----------------------------------------------------------------------------
module spm_mac #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   a,
   input  logic               signed_mode,
   input  logic               accumulate,
   output logic               serial_y,
   output logic               serial_valid,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW);
   // Partial-sum width. Two guard bits keep the running sum exact in both
   // modes. In unsigned mode it stays below 2^(WIDTH+1). In signed mode it
   // stays within [-2^WIDTH, 2^WIDTH).
   localparam int SW = WIDTH + 2;
   localparam logic [CW-1:0] LAST = CW'(PW - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [SW-1:0]    a_reg;         // multiplicand, already extended to SW bits
   logic [WIDTH-1:0] xs_reg;        // unconsumed multiplier bits, LSB next
   logic             xsign_reg;     // fill bit for x beyond its MSB
   logic             acc_reg;
   logic [CW-1:0]    cnt_reg;       // index of the bit currently on serial_y
   logic [SW-1:0]    r_reg;         // running partial sum, already shifted
   logic [PW-1:0]    prod_reg;      // collected product bits (shift in at MSB)
   logic [PW-1:0]    p_reg;
   logic             serial_y_reg;

   logic             accept;
   logic             x_sign_in;
   logic [SW-1:0]    a_in_ext;
   logic [SW-1:0]    a_sel;
   logic             x_bit;
   logic [SW-1:0]    r_sel;
   logic [SW-1:0]    pp;
   logic [SW-1:0]    t;
   logic [SW-1:0]    r_next;

   assign accept    = (state_reg == IDLE) && in_valid;
   assign x_sign_in = signed_mode & x[WIDTH-1];
   assign a_in_ext  = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};

   // The accept edge already produces product bit 0 from the raw inputs.
   // This puts bit k on serial_y between edges E0+k and E0+k+1.
   assign a_sel = accept ? a_in_ext : a_reg;
   assign x_bit = accept ? x[0]     : xs_reg[0];
   assign r_sel = accept ? '0       : r_reg;

   // Partial product: the multiplicand gated by the current multiplier bit.
   for (genvar gi = 0; gi < SW; gi++) begin : g_pp
      assign pp[gi] = a_sel[gi] & x_bit;
   end

   // Add the partial product. Its LSB is the final product bit for this
   // weight. The rest carries into the next weight (arithmetic shift).
   assign t      = r_sel + pp;
   assign r_next = {t[SW-1], t[SW-1:1]};

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)         state_next = RUN;
         RUN:     if (cnt_reg == LAST)  state_next = DONE;
         DONE:    if (out_ready)        state_next = IDLE;
         default:                       state_next = IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_reg        <= '0;
         xs_reg       <= '0;
         xsign_reg    <= 1'b0;
         acc_reg      <= 1'b0;
         cnt_reg      <= '0;
         r_reg        <= '0;
         prod_reg     <= '0;
         p_reg        <= '0;
         serial_y_reg <= 1'b0;
      end else if (accept) begin
         a_reg        <= a_in_ext;
         xs_reg       <= {x_sign_in, x[WIDTH-1:1]};
         xsign_reg    <= x_sign_in;
         acc_reg      <= accumulate;
         cnt_reg      <= '0;
         r_reg        <= r_next;
         prod_reg     <= {t[0], prod_reg[PW-1:1]};
         serial_y_reg <= t[0];
      end else if (state_reg == RUN) begin
         if (cnt_reg == LAST) begin
            // All 2*WIDTH bits have been shifted into prod_reg by now.
            p_reg        <= acc_reg ? (p_reg + prod_reg) : prod_reg;
            serial_y_reg <= 1'b0;
         end else begin
            cnt_reg      <= cnt_reg + CW'(1);
            xs_reg       <= {xsign_reg, xs_reg[WIDTH-1:1]};
            r_reg        <= r_next;
            prod_reg     <= {t[0], prod_reg[PW-1:1]};
            serial_y_reg <= t[0];
         end
      end
   end

   assign in_ready     = (state_reg == IDLE);
   assign busy         = (state_reg != IDLE);
   assign serial_valid = (state_reg == RUN);
   assign out_valid    = (state_reg == DONE);
   assign serial_y     = serial_y_reg;
   assign p            = p_reg;

endmodule

// File: tb/tb_spm_mac.sv
// -----------------------------------------------------------------------------
// tb_spm_mac -- self-checking bench for spm_mac.
// Three instances (WIDTH = 8, 32, 5) are exercised one at a time.
// A behavioural model (a wide integer multiply plus masking) predicts every
// product and accumulator value.
// -----------------------------------------------------------------------------
module tb_spm_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        iv  [3];
   logic        orr [3];
   logic [31:0] xv  [3];
   logic [31:0] av  [3];
   logic        smv [3];
   logic        acv [3];
   logic        ir  [3];
   logic        sy  [3];
   logic        sv  [3];
   logic        bz  [3];
   logic        ov  [3];

   logic [15:0] p8;
   logic [63:0] p32;
   logic [9:0]  p5;
   logic [63:0] pv  [3];

   assign pv[0] = {48'd0, p8};
   assign pv[1] = p32;
   assign pv[2] = {54'd0, p5};

   int          wid [3] = '{8, 32, 5};
   logic [63:0] model_p [3];

   int total = 0;
   int bad   = 0;

   spm_mac #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .x(xv[0][7:0]), .a(av[0][7:0]), .signed_mode(smv[0]), .accumulate(acv[0]),
      .serial_y(sy[0]), .serial_valid(sv[0]), .busy(bz[0]), .out_valid(ov[0]),
      .out_ready(orr[0]), .p(p8)
   );

   spm_mac #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .x(xv[1]), .a(av[1]), .signed_mode(smv[1]), .accumulate(acv[1]),
      .serial_y(sy[1]), .serial_valid(sv[1]), .busy(bz[1]), .out_valid(ov[1]),
      .out_ready(orr[1]), .p(p32)
   );

   spm_mac #(.WIDTH(5)) u_w5 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .x(xv[2][4:0]), .a(av[2][4:0]), .signed_mode(smv[2]), .accumulate(acv[2]),
      .serial_y(sy[2]), .serial_valid(sv[2]), .busy(bz[2]), .out_valid(ov[2]),
      .out_ready(orr[2]), .p(p5)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [63:0] wmask(input int w);
      if (w >= 32) return '1;
      return (64'd1 << (2 * w)) - 64'd1;
   endfunction

   // Reference product: extend both operands to 128 bits, multiply, and keep
   // the low 2*w bits.
   function automatic logic [63:0] ref_prod(input int w, input logic [31:0] xi,
                                            input logic [31:0] ai, input logic smi);
      logic [127:0] lm, xe, ae, pr;
      lm = (128'd1 << w) - 128'd1;
      xe = {96'd0, xi} & lm;
      ae = {96'd0, ai} & lm;
      if (smi && (((xi >> (w - 1)) & 32'd1) != 32'd0)) xe = xe | ~lm;
      if (smi && (((ai >> (w - 1)) & 32'd1) != 32'd0)) ae = ae | ~lm;
      pr = xe * ae;
      return pr[63:0] & wmask(w);
   endfunction

   // One full transaction. Entered and left at 1 time unit after a rising edge.
   task automatic do_op(input logic [1:0] d, input logic [31:0] xi, input logic [31:0] ai,
                        input logic smi, input logic aci, input int stall, input logic hold_iv);
      int          w;
      logic [63:0] prod, want, stream;
      logic        run_ok, stable;
      w      = wid[d];
      prod   = ref_prod(w, xi, ai, smi);
      want   = aci ? ((model_p[d] + prod) & wmask(w)) : prod;
      chk("in_ready_idle", ir[d], 1);
      xv[d]  = xi;
      av[d]  = ai;
      smv[d] = smi;
      acv[d] = aci;
      iv[d]  = 1'b1;
      @(posedge clk); #1;
      // Operands are don't-care after the accept edge: scramble them.
      iv[d]  = 1'b0;
      xv[d]  = $urandom;
      av[d]  = $urandom;
      smv[d] = ~smi;
      acv[d] = ~aci;
      stream = '0;
      run_ok = 1'b1;
      for (int k = 0; k < 2 * w; k++) begin
         stream = stream | (64'(sy[d]) << k);
         if (sv[d] !== 1'b1 || ov[d] !== 1'b0 || bz[d] !== 1'b1 || ir[d] !== 1'b0)
            run_ok = 1'b0;
         @(posedge clk); #1;
      end
      chk("run_flags", run_ok, 1);
      chk("serial_stream", stream, prod);
      chk("out_valid_at_latency", ov[d], 1);
      chk("serial_valid_fall", sv[d], 0);
      chk("p_result", pv[d], want);
      model_p[d] = want;
      iv[d] = hold_iv;
      if (stall > 0) begin
         stable = 1'b1;
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (ov[d] !== 1'b1 || pv[d] !== want || ir[d] !== 1'b0 || bz[d] !== 1'b1)
               stable = 1'b0;
         end
         chk("backpressure_hold", stable, 1);
      end
      orr[d] = 1'b1;
      @(posedge clk); #1;
      orr[d] = 1'b0;
      iv[d]  = 1'b0;
      // in_ready=1 here also proves no accept on the handshake edge.
      chk("handshake_idle", ir[d], 1);
      chk("busy_low_after", bz[d], 0);
      chk("p_after_handshake", pv[d], want);
      $display("txn w=%0d x=%h a=%h signed=%0d acc=%0d stall=%0d p=%h",
               w, xi, ai, smi, aci, stall, pv[d]);
   endtask

   // Directed WIDTH=8 vectors with hand-computed results
   logic [7:0]  dx  [10] = '{8'hFF, 8'h00, 8'hFF, 8'h80, 8'h80, 8'h7F, 8'h03, 8'h02, 8'hFF, 8'hFF};
   logic [7:0]  da  [10] = '{8'hFF, 8'hA5, 8'hFF, 8'h80, 8'h7F, 8'h7F, 8'h05, 8'h07, 8'hFF, 8'hFF};
   logic        dsm [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic        dac [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [15:0] dex [10] = '{16'hFE01, 16'h0000, 16'h0001, 16'h4000, 16'hC080,
                             16'h3F01, 16'h000F, 16'h001D, 16'hFE01, 16'hFC02};

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; orr[i] = 1'b0; xv[i] = '0; av[i] = '0;
         smv[i] = 1'b0; acv[i] = 1'b0; model_p[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", ir[0], 1);
      chk("rst_busy", bz[0], 0);
      chk("rst_out_valid", ov[0], 0);
      chk("rst_serial_valid", sv[0], 0);
      chk("rst_serial_y", sy[0], 0);
      chk("rst_p", pv[0], 0);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // Directed corners at WIDTH=8
      for (int i = 0; i < 10; i++) begin
         do_op(2'd0, {24'd0, dx[i]}, {24'd0, da[i]}, dsm[i], dac[i], 0, 1'b0);
         chk("directed_const", pv[0], {48'd0, dex[i]});
      end

      // Backpressure: 10 stalled cycles with in_valid held high
      do_op(2'd0, 32'h12, 32'h34, 1'b0, 1'b0, 10, 1'b1);
      chk("bp_const", pv[0], 64'h03A8);

      // Reset in the 5th RUN cycle
      xv[0] = 32'h5A; av[0] = 32'h3C; smv[0] = 1'b0; acv[0] = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", ir[0], 1);
      chk("mid_rst_busy", bz[0], 0);
      chk("mid_rst_out_valid", ov[0], 0);
      chk("mid_rst_serial_valid", sv[0], 0);
      chk("mid_rst_serial_y", sy[0], 0);
      chk("mid_rst_p", pv[0], 0);
      for (int i = 0; i < 3; i++) model_p[i] = '0;
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_no_out_valid", ov[0], 0);
      do_op(2'd0, 32'd6, 32'd9, 1'b0, 1'b0, 0, 1'b0);
      chk("post_rst_const", pv[0], 64'h0036);

      // Randomised runs: a few at WIDTH=8, then 200 each at WIDTH=32 and WIDTH=5
      for (int n = 0; n < 40; n++)
         do_op(2'd0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int n = 0; n < 200; n++)
         do_op(2'd1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int n = 0; n < 200; n++)
         do_op(2'd2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
